// File: rtl/wb_queue.sv
// Writeback buffer: in-order circular queue, one push per cycle, up to two drains per cycle.
// Optional forwarding lookup is built only when WBQ_FWD_EN is defined.
module wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 15,
  parameter int unsigned REG_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [REG_W-1:0]           push_sel,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       hold,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wr1_en,
  output logic [REG_W-1:0]           wr1_sel,
  output logic [DATA_W-1:0]          wr1_data,
  output logic                       wr2_en,
  output logic [REG_W-1:0]           wr2_sel,
  output logic [DATA_W-1:0]          wr2_data,
  input  logic [REG_W-1:0]           fwd_sel,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [REG_W-1:0]  sel_q  [DEPTH];
  logic [REG_W-1:0]  sel_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, head_nx;
  logic [CW-1:0]     count_q, count_d, drained;
  logic              push_acc;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    head_nx  = head_q + PW'(1);
    wr1_en   = !hold && (count_q != '0);
    // A same-register pair must not hit both ports at once; the younger waits a cycle.
    wr2_en   = !hold && (count_q >= CW'(2)) && (sel_q[head_nx] != sel_q[head_q]);
    wr1_sel  = wr1_en ? sel_q[head_q]   : '0;
    wr1_data = wr1_en ? data_q[head_q]  : '0;
    wr2_sel  = wr2_en ? sel_q[head_nx]  : '0;
    wr2_data = wr2_en ? data_q[head_nx] : '0;

    push_acc = push_valid && !full;
    drained  = CW'(wr1_en) + CW'(wr2_en);
    count_d  = count_q + CW'(push_acc) - drained;
    head_d   = head_q + PW'(drained);
    tail_d   = push_acc ? tail_q + PW'(1) : tail_q;

    sel_d  = sel_q;
    data_d = data_q;
    if (push_acc) begin
      sel_d[tail_q]  = push_sel;
      data_d[tail_q] = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    sel_q  <= sel_d;
    data_q <= data_d;
  end

`ifdef WBQ_FWD_EN
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    // Scan oldest to youngest so the youngest match wins.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(i) < count_q) && (sel_q[head_q + PW'(i)] == fwd_sel)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
    end
  end
`else
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^fwd_sel;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [3:0]  push_sel = '0;
  logic [14:0] push_data = '0;
  logic        hold = 1'b0;
  logic [3:0]  fwd_sel = '0;
  logic        full, empty, wr1_en, wr2_en, fwd_hit;
  logic [2:0]  count;
  logic [3:0]  wr1_sel, wr2_sel;
  logic [14:0] wr1_data, wr2_data, fwd_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0]  msel [$];
  logic [14:0] mdat [$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(4), .DATA_W(15), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_sel(push_sel),
    .push_data(push_data), .hold(hold), .full(full), .empty(empty), .count(count),
    .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_sel(wr2_sel), .wr2_data(wr2_data),
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model mid-cycle,
  // then advance the model by the queue rules.
  task automatic cycle(input logic pv, input logic [3:0] s, input logic [14:0] d,
                       input logic h, input logic [3:0] fs);
    int sz;
    logic e1, e2, hit;
    logic [14:0] fdat;
    push_valid = pv; push_sel = s; push_data = d; hold = h; fwd_sel = fs;
    #3;
    sz = msel.size();
    e1 = !h && sz >= 1;
    e2 = !h && sz >= 2 && (msel[1] != msel[0]);
    chk("full",  full,  sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("count", count, sz);
    chk("wr1_en", wr1_en, e1);
    chk("wr1_sel",  wr1_sel,  e1 ? msel[0] : 4'd0);
    chk("wr1_data", wr1_data, e1 ? mdat[0] : 15'd0);
    chk("wr2_en", wr2_en, e2);
    chk("wr2_sel",  wr2_sel,  e2 ? msel[1] : 4'd0);
    chk("wr2_data", wr2_data, e2 ? mdat[1] : 15'd0);
    hit = 1'b0; fdat = '0;
`ifdef WBQ_FWD_EN
    for (int j = sz - 1; j >= 0; j--) begin
      if (msel[j] == fs) begin hit = 1'b1; fdat = mdat[j]; break; end
    end
`endif
    chk("fwd_hit",  fwd_hit,  hit);
    chk("fwd_data", fwd_data, fdat);
    @(posedge clk);
    #1;
    if (e1) begin void'(msel.pop_front()); void'(mdat.pop_front()); end
    if (e2) begin void'(msel.pop_front()); void'(mdat.pop_front()); end
    if (pv && sz < DEPTH) begin msel.push_back(s); mdat.push_back(d); end
  endtask

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_wr1_en", wr1_en, 0);
    chk("rst_wr2_en", wr2_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two distinct registers drain together.
    cycle(1, 4'd1, 15'h1234, 1, 0);
    cycle(1, 4'd2, 15'h0042, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t1_empty", empty, 1);
    cycle(0, 0, 0, 0, 0);

    // Same-register pair drains one per cycle.
    cycle(1, 4'd3, 15'h0001, 1, 0);
    cycle(1, 4'd3, 15'h0002, 1, 3);
    cycle(0, 0, 0, 0, 3);
    cycle(0, 0, 0, 0, 3);
    cycle(0, 0, 0, 0, 0);

    // Fill past capacity; fifth push is dropped.
    for (int i = 0; i < 5; i++) cycle(1, 4'(i + 8), 15'(16'h0100 + i), 1, 0);
    chk("t3_full", full, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    chk("t3_empty", empty, 1);

    // Continuous pushes with hold toggling every three cycles, across wrap.
    for (int i = 0; i < 12; i++) begin
      cycle(1, 4'(i), 15'(16'h0200 + i), ((i / 3) % 2) == 0, 4'(i));
      chk("t4_cnt_le_depth", count <= 3'd4, 1);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);

    // Forwarding: youngest match wins; a miss reads zero.
    cycle(1, 4'd5, 15'h0111, 1, 5);
    cycle(1, 4'd5, 15'h0222, 1, 5);
    cycle(0, 0, 0, 1, 5);
`ifdef WBQ_FWD_EN
    chk("t6_fwd_hit5", fwd_hit, 1);
    chk("t6_fwd_dat5", fwd_data, 15'h0222);
`endif
    cycle(0, 0, 0, 1, 6);
    chk("t6_fwd_miss", fwd_hit, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

    // Asynchronous reset with entries queued.
    cycle(1, 4'd1, 15'h0aaa, 1, 0);
    cycle(1, 4'd2, 15'h0bbb, 1, 0);
    cycle(1, 4'd3, 15'h0ccc, 1, 0);
    hold = 1'b0; push_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_count", count, 0);
    chk("t5_wr1_en", wr1_en, 0);
    chk("t5_wr2_en", wr2_en, 0);
    chk("t5_empty", empty, 1);
    rst = 1'b0;
    msel.delete(); mdat.delete();
    @(posedge clk); #1;
    cycle(1, 4'd7, 15'h7fff, 0, 7);
    chk("t5_wr1_sel", wr1_sel, 4'd7);
    chk("t5_wr1_dat", wr1_data, 15'h7fff);
    cycle(0, 0, 0, 0, 0);

    // Random traffic; narrow register range exercises same-sel pairs.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 15'($urandom),
            $urandom_range(0, 9) < 3, 4'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
